// File: rtl/dpll_pkg.sv
// dpll_pkg: widths shared with the loop filter and the saturating FCW adder
package dpll_pkg;
  localparam int ACC_W = 32;
  localparam int CTRL_W = 20;
  typedef struct packed {
    logic ovf;
    logic [ACC_W-1:0] sum;
  } sat_t;
  function automatic sat_t sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + b;
    return s[ACC_W] ? sat_t'{ovf: 1'b1, sum: '1} : sat_t'{ovf: 1'b0, sum: s[ACC_W-1:0]};
  endfunction
endpackage

// File: rtl/fb_divider.sv
// fb_divider: toggles fb_out every DIV_N/2 accumulator wraps, frozen while en is low
module fb_divider #(
  parameter int DIV_N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic wrap_pulse,
  input  logic en,
  output logic fb_out
);
  localparam int CW = DIV_N > 2 ? $clog2(DIV_N / 2) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_N / 2 - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      fb_out <= 1'b0;
    end else if (en && wrap_pulse) begin
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
      fb_out <= cnt == LAST ? ~fb_out : fb_out;
    end
  end
endmodule

// File: rtl/dco_nco.sv
// dco_nco: control word to saturated FCW, phase accumulator NCO and divided feedback clock
module dco_nco
  import dpll_pkg::*;
#(
  parameter logic [ACC_W-1:0] BASE_FCW = 32'h0100_0000,
  parameter int CTRL_SHIFT = 4,
  parameter int DIV_N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              ctrl_valid,
  output logic [ACC_W-1:0]  fcw,
  output logic              nco_out,
  output logic              wrap_pulse,
  output logic              fb_out,
  output logic              sat_flag
);
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] ctrl_ext;
  sat_t nxt;
  assign ctrl_ext = {{(ACC_W + 1 - CTRL_W){1'b0}}, ctrl} << CTRL_SHIFT;
  assign nxt = sat_add(BASE_FCW, ctrl_ext);
  assign nco_out = acc[ACC_W-1];
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
      fcw <= BASE_FCW;
      wrap_pulse <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (ctrl_valid) begin
        fcw <= nxt.sum;
        sat_flag <= nxt.ovf;
      end
      if (en) {wrap_pulse, acc} <= {1'b0, acc} + {1'b0, fcw};
      else wrap_pulse <= 1'b0;
    end
  end
  fb_divider #(.DIV_N(DIV_N)) u_div (
    .clk(clk),
    .rst(rst),
    .wrap_pulse(wrap_pulse),
    .en(en),
    .fb_out(fb_out)
  );
endmodule

// File: tb/tb_dco_nco.sv
// tb_dco_nco: directed scenario tasks against hand-derived NCO timing and a small reference model
module tb_dco_nco;
  import dpll_pkg::*;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, ctrl_valid = 1'b0;
  logic [CTRL_W-1:0] ctrl = '0;
  logic [ACC_W-1:0] fcw, fcw_s;
  logic nco_out, wrap_pulse, fb_out, sat_flag;
  logic nco_s, wrap_s, fb_s, sat_s;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  dco_nco dut (
    .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .ctrl_valid(ctrl_valid),
    .fcw(fcw), .nco_out(nco_out), .wrap_pulse(wrap_pulse), .fb_out(fb_out), .sat_flag(sat_flag)
  );
  dco_nco #(.CTRL_SHIFT(12)) dut_s (
    .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .ctrl_valid(ctrl_valid),
    .fcw(fcw_s), .nco_out(nco_s), .wrap_pulse(wrap_s), .fb_out(fb_s), .sat_flag(sat_s)
  );
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    rst = 1'b0; en = 1'b1; ctrl = 20'hFFFFF; ctrl_valid = 1'b1;
    tick(2);
    checks++;
    if (fcw !== 32'h0100_0000) begin fails++; $display("FAIL reset_fcw: got %h want 01000000", fcw); end
    checks++;
    if ({nco_out, wrap_pulse, fb_out, sat_flag} !== 4'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 0000", {nco_out, wrap_pulse, fb_out, sat_flag});
    end
    checks++;
    if (fcw_s !== 32'h0100_0000 || sat_s !== 1'b0) begin
      fails++; $display("FAIL reset_sat_inst: got %h/%b want 01000000/0", fcw_s, sat_s);
    end
    en = 1'b0; ctrl_valid = 1'b0; ctrl = '0;
    tick();
    rst = 1'b1;
  endtask
  task automatic test_ctrl_zero;
    ctrl = '0; ctrl_valid = 1'b1;
    tick();
    ctrl_valid = 1'b0;
    checks++;
    if (fcw !== 32'h0100_0000 || sat_flag !== 1'b0) begin
      fails++; $display("FAIL ctrl0_fcw: got %h/%b want 01000000/0", fcw, sat_flag);
    end
    en = 1'b1;
    tick(127);
    checks++;
    if (nco_out !== 1'b0) begin fails++; $display("FAIL nco_127: got %b want 0", nco_out); end
    tick();
    checks++;
    if (nco_out !== 1'b1 || wrap_pulse !== 1'b0) begin
      fails++; $display("FAIL nco_128: got nco %b wrap %b want 1 0", nco_out, wrap_pulse);
    end
    tick(127);
    checks++;
    if (wrap_pulse !== 1'b0 || nco_out !== 1'b1) begin
      fails++; $display("FAIL wrap_255: got wrap %b nco %b want 0 1", wrap_pulse, nco_out);
    end
    tick();
    checks++;
    if (wrap_pulse !== 1'b1 || nco_out !== 1'b0) begin
      fails++; $display("FAIL wrap_256: got wrap %b nco %b want 1 0", wrap_pulse, nco_out);
    end
    tick();
    checks++;
    if (wrap_pulse !== 1'b0) begin fails++; $display("FAIL wrap_257: got %b want 0", wrap_pulse); end
  endtask
  task automatic test_fb_divider;
    tick(767);
    checks++;
    if (fb_out !== 1'b0) begin fails++; $display("FAIL fb_1024: got %b want 0", fb_out); end
    tick();
    checks++;
    if (fb_out !== 1'b1) begin fails++; $display("FAIL fb_1025: got %b want 1", fb_out); end
    tick(1023);
    checks++;
    if (fb_out !== 1'b1) begin fails++; $display("FAIL fb_2048: got %b want 1", fb_out); end
    tick();
    checks++;
    if (fb_out !== 1'b0) begin fails++; $display("FAIL fb_2049: got %b want 0", fb_out); end
  endtask
  task automatic test_en_freeze;
    tick(51);
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if ({nco_out, wrap_pulse, fb_out} !== 3'b000) begin
        fails++; $display("FAIL freeze_%0d: got nco/wrap/fb %b want 000", i, {nco_out, wrap_pulse, fb_out});
      end
    end
    en = 1'b1;
    tick(203);
    checks++;
    if (wrap_pulse !== 1'b0) begin fails++; $display("FAIL resume_203: got %b want 0", wrap_pulse); end
    tick();
    checks++;
    if (wrap_pulse !== 1'b1) begin fails++; $display("FAIL resume_204: got %b want 1", wrap_pulse); end
  endtask
  task automatic test_saturation;
    ctrl = 20'hFFFFF; ctrl_valid = 1'b1;
    tick();
    ctrl_valid = 1'b0;
    checks++;
    if (fcw !== 32'h01FF_FFF0 || sat_flag !== 1'b0) begin
      fails++; $display("FAIL fcw_max_shift4: got %h/%b want 01fffff0/0", fcw, sat_flag);
    end
    checks++;
    if (fcw_s !== 32'hFFFF_FFFF || sat_s !== 1'b1) begin
      fails++; $display("FAIL fcw_sat_shift12: got %h/%b want ffffffff/1", fcw_s, sat_s);
    end
    ctrl = '0;
    tick();
    checks++;
    if (fcw_s !== 32'hFFFF_FFFF || sat_s !== 1'b1) begin
      fails++; $display("FAIL fcw_hold: got %h/%b want ffffffff/1", fcw_s, sat_s);
    end
    ctrl_valid = 1'b1;
    tick();
    ctrl_valid = 1'b0;
    checks++;
    if (fcw_s !== 32'h0100_0000 || sat_s !== 1'b0 || fcw !== 32'h0100_0000) begin
      fails++; $display("FAIL sat_clear: got %h/%b/%h want 01000000/0/01000000", fcw_s, sat_s, fcw);
    end
  endtask
  task automatic test_coincident;
    logic [ACC_W-1:0] acc_m, fcw_m;
    logic [ACC_W:0] s;
    logic wrap_m, fb_m, cv;
    int cnt_m;
    rst = 1'b0; en = 1'b0; ctrl_valid = 1'b0;
    tick();
    rst = 1'b1; en = 1'b1; ctrl = 20'hFFFFF;
    acc_m = '0; fcw_m = 32'h0100_0000; wrap_m = 1'b0; fb_m = 1'b0; cnt_m = 0;
    for (int i = 1; i <= 700; i++) begin
      cv = (i == 256);
      ctrl_valid = cv;
      tick();
      ctrl_valid = 1'b0;
      if (wrap_m) begin
        if (cnt_m == 3) begin cnt_m = 0; fb_m = ~fb_m; end
        else cnt_m++;
      end
      {wrap_m, acc_m} = {1'b0, acc_m} + {1'b0, fcw_m};
      if (cv) begin
        s = {1'b0, 32'h0100_0000} + ({13'b0, ctrl} << 4);
        fcw_m = s[ACC_W] ? '1 : s[ACC_W-1:0];
      end
      checks++;
      if ({nco_out, wrap_pulse, fb_out, fcw} !== {acc_m[ACC_W-1], wrap_m, fb_m, fcw_m}) begin
        fails++;
        $display("FAIL coincide_%0d: got nco/wrap/fb %b fcw %h want %b fcw %h", i,
                 {nco_out, wrap_pulse, fb_out}, fcw, {acc_m[ACC_W-1], wrap_m, fb_m}, fcw_m);
      end
    end
  endtask
  task automatic test_mid_reset;
    rst = 1'b0; ctrl = 20'hFFFFF; ctrl_valid = 1'b1;
    tick();
    ctrl_valid = 1'b0;
    checks++;
    if (fcw !== 32'h0100_0000 || {nco_out, wrap_pulse, fb_out, sat_flag} !== 4'b0) begin
      fails++; $display("FAIL midrst: got fcw %h flags %b want 01000000 0000", fcw, {nco_out, wrap_pulse, fb_out, sat_flag});
    end
    checks++;
    if (fcw_s !== 32'h0100_0000 || sat_s !== 1'b0) begin
      fails++; $display("FAIL midrst_sat: got %h/%b want 01000000/0", fcw_s, sat_s);
    end
    rst = 1'b1;
    tick(255);
    checks++;
    if (wrap_pulse !== 1'b0) begin fails++; $display("FAIL midrst_255: got %b want 0", wrap_pulse); end
    tick();
    checks++;
    if (wrap_pulse !== 1'b1) begin fails++; $display("FAIL midrst_256: got %b want 1", wrap_pulse); end
  endtask
  initial begin
    test_reset();
    test_ctrl_zero();
    test_fb_divider();
    test_en_freeze();
    test_saturation();
    test_coincident();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/dco_nco.md
Name: dco_nco

Overview:
- Digitally controlled oscillator stage directly downstream of the PI loop filter.
- Consumes the filter's 20-bit control word and converts it into a frequency control word (FCW) for a phase accumulator.
- Produces a square-wave NCO output and a divided feedback clock, which return to the phase detector to close the DPLL loop.

Parameters:
- ACC_W, 32, phase accumulator width in bits.
- CTRL_W, 20, control word width; must equal the loop filter output width.
- BASE_FCW, 32'h0100_0000, free-running FCW applied when ctrl = 0.
- CTRL_SHIFT, 4, left shift applied to ctrl before it is added to BASE_FCW.
- DIV_N, 8, feedback divide ratio in NCO periods; must be even and >= 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  accumulator enable.
- ctrl  input  CTRL_W  control word from the loop filter (unsigned).
- ctrl_valid  input  1  ctrl is sampled on any edge where this is high.
- fcw  output  ACC_W  currently applied FCW (registered).
- nco_out  output  1  MSB of the phase accumulator.
- wrap_pulse  output  1  one-cycle pulse on accumulator carry-out.
- fb_out  output  1  divided feedback clock to the phase detector.
- sat_flag  output  1  high while fcw is saturated.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-low, named rst. Clock is named clk.
  - When rst = 0 at an edge: acc = 0, fcw = BASE_FCW, nco_out = 0, wrap_pulse = 0, fb_out = 0, divider count = 0, sat_flag = 0.
  - Reset dominates en and ctrl_valid. Reset asserted mid-operation discards phase and divider state at that edge.
- FCW update:
  - On an edge with ctrl_valid = 1, compute sum = BASE_FCW + (ctrl << CTRL_SHIFT) at ACC_W+1 bits.
  - If sum > 2^ACC_W - 1: fcw <= all ones and sat_flag <= 1. Otherwise fcw <= sum[ACC_W-1:0] and sat_flag <= 0.
  - With ctrl_valid = 0, fcw and sat_flag hold.
  - FCW updates are independent of en.
- Accumulator:
  - On an edge with en = 1: {carry, acc} <= acc + fcw, using the fcw value before that edge. A new ctrl takes effect in the accumulator one edge after it is sampled.
  - wrap_pulse <= carry.
  - With en = 0: acc holds and wrap_pulse <= 0.
- nco_out equals acc[ACC_W-1], driven directly from the register with no extra latency.
- Feedback divider:
  - Counter cnt is width clog2(DIV_N/2), default 0.
  - The divider is stepped by the registered wrap_pulse: on an edge where wrap_pulse = 1, if cnt == DIV_N/2 - 1 then cnt <= 0 and fb_out toggles; otherwise cnt increments.
  - fb_out therefore has a period of DIV_N accumulator wraps, with a 50% duty cycle.
- Boundaries:
  - ctrl = 0 gives fcw = BASE_FCW.
  - ctrl_valid arriving on the same edge as a wrap: the wrap is computed with the old fcw.
  - Accumulator wrap-around is modulo 2^ACC_W, and the carry is never lost.
  - With en low, fb_out and cnt freeze.

Decomposition:
- dpll_pkg holds:
  - the ACC_W and CTRL_W constants, shared with the loop filter;
  - the sat_add function (saturating unsigned add with overflow flag).
- One sub-module, fb_divider:
  - inputs: clk, rst, wrap_pulse, en;
  - output: fb_out;
  - parameter: DIV_N.
- The top level holds the FCW register, the accumulator and the saturation logic.

Test Plan:
- Reset with defaults, ctrl = 0, ctrl_valid = 1 once, en = 1:
  - fcw = 32'h0100_0000;
  - first wrap_pulse high exactly 256 cycles after the first enabled edge;
  - nco_out toggles every 128 cycles.
- fb_out with DIV_N = 8 and ctrl = 0: toggles every 4 wraps (1024 cycles), giving a period of 2048 cycles.
- ctrl = 20'hFFFFF with default parameters: fcw = 0x01FF_FFF0, sat_flag = 0. With CTRL_SHIFT = 12: fcw = 0xFFFF_FFFF, sat_flag = 1. Then ctrl = 0: sat_flag returns to 0.
- en deasserted for 50 cycles mid-count: acc, cnt and fb_out are frozen and wrap_pulse = 0. On re-enable, wrap timing resumes offset by exactly 50 cycles.
- ctrl_valid coincident with a wrap edge: that wrap uses the old fcw, and the next accumulation uses the new fcw (checked against a reference model).
- rst pulled low for one edge mid-run: all outputs match reset values at the next edge, and fcw = BASE_FCW.
